// File: rtl/gtxe2_chnl_pkg.sv
// Shared definitions for the GTXE2 channel TX/RX rate-change sequencers.
package gtxe2_chnl_pkg;

  localparam logic [2:0] RATE_DEFAULT = 3'b000;
  localparam logic [2:0] RATE_DIV1    = 3'b001;
  localparam logic [2:0] RATE_DIV2    = 3'b010;
  localparam logic [2:0] RATE_DIV4    = 3'b011;
  localparam logic [2:0] RATE_DIV8    = 3'b100;
  localparam logic [2:0] RATE_DIV16   = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StSettle,
    StDone
  } rate_state_e;

  // Codes 110/111 are reserved and behave as the default rate.
  function automatic logic [2:0] norm_rate(input logic [2:0] code);
    return (code == 3'b110 || code == 3'b111) ? RATE_DEFAULT : code;
  endfunction

  function automatic logic [4:0] rate_to_div(input logic [2:0] code,
                                             input int unsigned txout_div);
    logic [4:0] div;
    unique case (code)
      RATE_DIV1:  div = 5'd1;
      RATE_DIV2:  div = 5'd2;
      RATE_DIV4:  div = 5'd4;
      RATE_DIV8:  div = 5'd8;
      RATE_DIV16: div = 5'd16;
      default:    div = txout_div[4:0];
    endcase
    return div;
  endfunction

endpackage

// File: rtl/gtxe2_chnl_tx_rate_ctrl_if.sv
// Fabric-side TXRATE request and divider control bundle of the TX rate sequencer.
interface gtxe2_chnl_tx_rate_ctrl_if;
  logic [2:0] TXRATE;
  logic [2:0] tx_rate_sel;
  logic [4:0] tx_serial_div;
  logic       tx_div_rst;
  logic       TXRATEDONE;
  logic       tx_rate_busy;

  modport master (
    output TXRATE,
    input  tx_rate_sel, tx_serial_div, tx_div_rst, TXRATEDONE, tx_rate_busy
  );

  modport slave (
    input  TXRATE,
    output tx_rate_sel, tx_serial_div, tx_div_rst, TXRATEDONE, tx_rate_busy
  );
endinterface

// File: rtl/gtxe2_chnl_rate_timer.sv
// Loadable down-counter that stops at zero and flags it.
module gtxe2_chnl_rate_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             zero
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/gtxe2_chnl_tx_rate_ctrl.sv
// TX line-rate change sequencer: holds the dividers in reset, switches the select,
// waits a settle interval and pulses TXRATEDONE.
module gtxe2_chnl_tx_rate_ctrl
  import gtxe2_chnl_pkg::*;
#(
  parameter int unsigned TXOUT_DIV     = 2,
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                            TXUSRCLK2,
  input  logic                            GTTXRESET,
  gtxe2_chnl_tx_rate_ctrl_if.slave        bus
);

  localparam int unsigned MaxCycles = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  rate_state_e state_q, state_d;
  logic [2:0]  target_q, target_d;
  logic [2:0]  rate_sel_q;
  logic [4:0]  serial_div_q;
  logic [2:0]  rate_norm;
  logic        apply;
  logic        load;
  logic [CntW-1:0] load_val;
  logic        cnt_zero;

  assign rate_norm = norm_rate(bus.TXRATE);

  gtxe2_chnl_rate_timer #(
    .Width (CntW)
  ) u_timer (
    .clk      (TXUSRCLK2),
    .rst      (GTTXRESET),
    .load     (load),
    .load_val (load_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    apply    = 1'b0;
    load     = 1'b0;
    load_val = '0;
    unique case (state_q)
      StIdle: begin
        if (rate_norm != rate_sel_q) begin
          state_d  = StHold;
          target_d = rate_norm;
          load     = 1'b1;
          load_val = CntW'(RST_CYCLES - 1);
        end
      end
      StHold: begin
        // Select switches on the same edge that releases the divider reset.
        if (cnt_zero) begin
          state_d  = StSettle;
          apply    = 1'b1;
          load     = 1'b1;
          load_val = CntW'(SETTLE_CYCLES - 1);
        end
      end
      StSettle: begin
        if (cnt_zero) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge TXUSRCLK2 or posedge GTTXRESET) begin
    if (GTTXRESET) begin
      state_q      <= StIdle;
      target_q     <= RATE_DEFAULT;
      rate_sel_q   <= RATE_DEFAULT;
      serial_div_q <= rate_to_div(RATE_DEFAULT, TXOUT_DIV);
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      if (apply) begin
        rate_sel_q   <= target_q;
        serial_div_q <= rate_to_div(target_q, TXOUT_DIV);
      end
    end
  end

  assign bus.tx_rate_sel   = rate_sel_q;
  assign bus.tx_serial_div = serial_div_q;
  assign bus.tx_div_rst    = (state_q == StHold);
  assign bus.TXRATEDONE    = (state_q == StDone);
  assign bus.tx_rate_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_gtxe2_chnl_tx_rate_ctrl.sv
// Directed bench for the TX rate sequencer with a completion scoreboard.
module tb_gtxe2_chnl_tx_rate_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  logic [7:0] exp_q[$];

  gtxe2_chnl_tx_rate_ctrl_if bus ();

  gtxe2_chnl_tx_rate_ctrl #(
    .TXOUT_DIV     (2),
    .RST_CYCLES    (4),
    .SETTLE_CYCLES (8)
  ) dut (
    .TXUSRCLK2 (clk),
    .GTTXRESET (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: each TXRATEDONE must match the oldest expected {sel, div}.
  always @(negedge clk) begin
    if (bus.TXRATEDONE === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("done_sel", {29'd0, bus.tx_rate_sel}, {29'd0, e[7:5]});
        check("done_div", {27'd0, bus.tx_serial_div}, {27'd0, e[4:0]});
        check("done_busy", {31'd0, bus.tx_rate_busy}, 32'd1);
      end
    end
  end

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.tx_rate_busy === 1'b0) break;
    end
    if (i == budget) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic set_rate(input logic [2:0] r);
    @(posedge clk);
    #1 bus.TXRATE = r;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel"},  {29'd0, bus.tx_rate_sel}, 32'd0);
    check({tag, "_div"},  {27'd0, bus.tx_serial_div}, 32'd2);
    check({tag, "_drst"}, {31'd0, bus.tx_div_rst}, 32'd0);
    check({tag, "_done"}, {31'd0, bus.TXRATEDONE}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.tx_rate_busy}, 32'd0);
  endtask

  initial begin
    int hi_cnt;
    bus.TXRATE = 3'b000;
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Idle at default rate: nothing happens for 50 cycles.
    repeat (50) @(negedge clk);
    check("idle_done_cnt", done_cnt, 32'd0);
    check_reset_outputs("idle");

    // 000 -> 011 with cycle-exact timing relative to E0.
    set_rate(3'b011);
    exp_q.push_back({3'b011, 5'd4});
    @(posedge clk);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check($sformatf("t_drst_%0d", k), {31'd0, bus.tx_div_rst}, (k <= 4) ? 32'd1 : 32'd0);
      check($sformatf("t_sel_%0d", k), {29'd0, bus.tx_rate_sel}, (k >= 5) ? 32'd3 : 32'd0);
      check($sformatf("t_div_%0d", k), {27'd0, bus.tx_serial_div}, (k >= 5) ? 32'd4 : 32'd2);
      check($sformatf("t_done_%0d", k), {31'd0, bus.TXRATEDONE}, (k == 13) ? 32'd1 : 32'd0);
      check($sformatf("t_busy_%0d", k), {31'd0, bus.tx_rate_busy}, (k <= 13) ? 32'd1 : 32'd0);
    end

    // Requests during busy: only the latest value survives to the next IDLE.
    set_rate(3'b100);
    exp_q.push_back({3'b100, 5'd8});
    repeat (3) set_rate(3'b001);
    repeat (3) set_rate(3'b101);
    exp_q.push_back({3'b101, 5'd16});
    wait_idle(80);
    check("busy_seq_done_cnt", done_cnt, 32'd3);

    // Return to default, then 000 -> 010 -> back to 000 while busy.
    set_rate(3'b000);
    exp_q.push_back({3'b000, 5'd2});
    wait_idle(40);
    set_rate(3'b010);
    exp_q.push_back({3'b010, 5'd2});
    repeat (2) set_rate(3'b000);
    exp_q.push_back({3'b000, 5'd2});
    wait_idle(80);
    check("return_sel", {29'd0, bus.tx_rate_sel}, 32'd0);
    check("return_div", {27'd0, bus.tx_serial_div}, 32'd2);
    check("return_done_cnt", done_cnt, 32'd6);

    // 111 normalizes to 000: no sequence.
    set_rate(3'b111);
    hi_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.tx_div_rst !== 1'b0 || bus.tx_rate_busy !== 1'b0) hi_cnt++;
    end
    check("norm_no_seq", hi_cnt, 32'd0);
    check("norm_done_cnt", done_cnt, 32'd6);

    // Reset mid-SETTLE, then a full sequence to 100.
    set_rate(3'b001);
    exp_q.push_back({3'b001, 5'd1});
    @(posedge clk);
    repeat (8) @(negedge clk);
    check("mid_busy", {31'd0, bus.tx_rate_busy}, 32'd1);
    check("mid_drst", {31'd0, bus.tx_div_rst}, 32'd0);
    check("mid_sel", {29'd0, bus.tx_rate_sel}, 32'd1);
    #2 rst = 1'b1;
    exp_q.delete();
    #1 check_reset_outputs("async_rst");
    bus.TXRATE = 3'b100;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.push_back({3'b100, 5'd8});
    wait_idle(40);
    check("post_rst_sel", {29'd0, bus.tx_rate_sel}, 32'd4);
    check("post_rst_div", {27'd0, bus.tx_serial_div}, 32'd8);
    check("final_done_cnt", done_cnt, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
